keypad_scanner: RTL and testbench

Scans the 4x4 matrix keypad on the channel strip's kpc/kpr pins and turns it into debounced key events for the front-panel control logic, which sets freqSelect, lowpassSelect and highpassSelect. Several jobs share one block:
- drives the active-low column selects;
- synchronises and samples the active-low rows;
- filters bounce and multi-key presses;
- issues a single-cycle event per press plus a held flag.

It is the input-side counterpart of the display path (displayMux/decode2/decode7) and runs on the top-level board clock.

---
 rtl/keypad_scanner.sv | 200 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad and turns it into debounced key
// events for the front-panel control logic.
//
// Ports
//   CLOCK_50   in   1  board clock, rising edge
//   reset_n    in   1  asynchronous active-low reset
//   kpc        out  4  column selects, active-low, exactly one bit low
//   kpr        in   4  row inputs, active-low, asynchronous to CLOCK_50
//   key_code   out  4  last accepted key, 4*row + col
//   key_valid  out  1  one-cycle pulse per accepted press
//   key_held   out  1  high from press acceptance until release acceptance
//
// Debounce FSM
//   state         | meaning
//   ST_IDLE       | no key accepted, waiting for a single-key scan
//   ST_PRESS_PEND | candidate key seen, counting matching scans
//   ST_HELD       | key_code accepted and still present
//   ST_REL_PEND   | accepted key missing, counting absent scans
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    output logic [3:0] kpc,
    input  logic [3:0] kpr,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DEB_W-1:0] DEB_TGT = DEB_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_PEND,
        ST_HELD,
        ST_REL_PEND
    } state_t;

    logic [3:0]       kpr_meta_q;
    logic [3:0]       kpr_s_q;
    logic [DIV_W-1:0] dwell_q;
    logic [1:0]       col_q;
    logic [3:0]       kpc_q;
    logic [15:0]      scan_q;
    logic [15:0]      scan_d;

    logic             dwell_last;
    logic             scan_end;
    logic             img_single;
    logic [3:0]       img_key;

    state_t           state_q;
    logic [3:0]       cand_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_inc;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_held_q;

    assign dwell_last = (dwell_q == DWELL_LAST);
    assign scan_end   = dwell_last && (col_q == 2'd3);
    assign deb_inc    = deb_cnt_q + DEB_W'(1);

    // Scan image including the sample taken this cycle, so the scan-end
    // classification sees column 3 without waiting an extra clock.
    always_comb begin
        scan_d = scan_q;
        if (dwell_last) begin
            for (int r = 0; r < 4; r++) begin
                scan_d[{r[1:0], col_q}] = ~kpr_s_q[r[1:0]];
            end
        end
    end

    assign img_single = (scan_d != 16'd0) && ((scan_d & (scan_d - 16'd1)) == 16'd0);

    always_comb begin
        img_key = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (scan_d[i[3:0]]) begin
                img_key = i[3:0];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            kpr_meta_q <= 4'hF;
            kpr_s_q    <= 4'hF;
            dwell_q    <= '0;
            col_q      <= 2'd0;
            kpc_q      <= 4'b1110;
            scan_q     <= 16'd0;
        end else begin
            kpr_meta_q <= kpr;
            kpr_s_q    <= kpr_meta_q;
            scan_q     <= scan_d;
            if (dwell_last) begin
                dwell_q <= '0;
                col_q   <= col_q + 2'd1;
                // Rotating the low bit keeps kpc glitch-free on the pins.
                kpc_q   <= {kpc_q[2:0], kpc_q[3]};
            end else begin
                dwell_q <= dwell_q + DIV_W'(1);
            end
        end
    end

    // MULTI images fail img_single and therefore behave exactly like NONE.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            deb_cnt_q   <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_end) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (img_single) begin
                            cand_q <= img_key;
                            if (DEBOUNCE == 1) begin
                                key_code_q  <= img_key;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                deb_cnt_q   <= '0;
                                state_q     <= ST_HELD;
                            end else begin
                                deb_cnt_q <= DEB_W'(1);
                                state_q   <= ST_PRESS_PEND;
                            end
                        end
                    end
                    ST_PRESS_PEND: begin
                        if (img_single && (img_key == cand_q)) begin
                            if (deb_inc == DEB_TGT) begin
                                key_code_q  <= cand_q;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                deb_cnt_q   <= '0;
                                state_q     <= ST_HELD;
                            end else begin
                                deb_cnt_q <= deb_inc;
                            end
                        end else if (img_single) begin
                            cand_q    <= img_key;
                            deb_cnt_q <= DEB_W'(1);
                        end else begin
                            deb_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (!(img_single && (img_key == key_code_q))) begin
                            if (DEBOUNCE == 1) begin
                                key_held_q <= 1'b0;
                                deb_cnt_q  <= '0;
                                state_q    <= ST_IDLE;
                            end else begin
                                deb_cnt_q <= DEB_W'(1);
                                state_q   <= ST_REL_PEND;
                            end
                        end
                    end
                    ST_REL_PEND: begin
                        if (img_single && (img_key == key_code_q)) begin
                            deb_cnt_q <= '0;
                            state_q   <= ST_HELD;
                        end else if (deb_inc == DEB_TGT) begin
                            key_held_q <= 1'b0;
                            deb_cnt_q  <= '0;
                            state_q    <= ST_IDLE;
                        end else begin
                            deb_cnt_q <= deb_inc;
                        end
                    end
                    default: begin
                        deb_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign kpc       = kpc_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE = 2.
// A keypad model pulls row r low while column c is selected and key
// 4*r + c is pressed. A reference model rebuilds every scan image from the
// recorded key history (a row is seen two clocks after the pin) and applies
// the press/release rules scan by scan.
module tb_keypad_scanner;

    localparam int SD   = 4;
    localparam int DEB  = 2;
    localparam int SCAN = 4 * SD;

    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_HELD = 2;
    localparam int M_REL  = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  kpc;
    logic [3:0]  kpr;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'd0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse = -1;
    int held_lows = 0;
    logic [15:0] hist [0:4095];

    int         m_st;
    int         m_cnt;
    logic [3:0] m_cand;
    logic [3:0] m_code;
    logic       m_held;
    logic       m_valid;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .kpc      (kpc),
        .kpr      (kpr),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        kpr = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (keys[i[3:0]] && !kpc[i[1:0]]) kpr[i[3:2]] = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_cand = 4'd0; m_code = 4'd0;
        m_held = 1'b0; m_valid = 1'b0;
    endtask

    // Apply one completed scan image to the reference rules.
    task automatic model_scan(input logic [15:0] img);
        int ones;
        logic [3:0] k;
        logic single;
        ones = 0; k = 4'd0;
        for (int i = 0; i < 16; i++) if (img[i]) begin ones++; k = i[3:0]; end
        single = (ones == 1);
        case (m_st)
            M_IDLE: if (single) begin m_cand = k; m_cnt = 1; m_st = M_PEND; end
            M_PEND: begin
                if (single && k == m_cand) begin
                    m_cnt++;
                    if (m_cnt >= DEB) begin
                        m_code = m_cand; m_held = 1'b1; m_valid = 1'b1; m_st = M_HELD;
                    end
                end else if (single) begin
                    m_cand = k; m_cnt = 1;
                end else m_st = M_IDLE;
            end
            M_HELD: if (!(single && k == m_code)) begin m_cnt = 1; m_st = M_REL; end
            default: begin
                if (single && k == m_code) m_st = M_HELD;
                else begin
                    m_cnt++;
                    if (m_cnt >= DEB) begin m_held = 1'b0; m_st = M_IDLE; end
                end
            end
        endcase
    endtask

    // Pin value for each period is what the synchroniser captures at its end.
    always @(posedge clk) begin
        if (reset_n) begin
            if (cyc < 4096) hist[cyc] = keys;
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && cyc > 0) begin
            logic [15:0] img;
            logic [3:0]  exp_kpc;
            int n;
            m_valid = 1'b0;
            if (cyc % SCAN == 0) begin
                n = cyc / SCAN - 1;
                img = 16'd0;
                for (int i = 0; i < 16; i++) begin
                    // column c is sampled on its last dwell cycle, seeing the pin 2 clocks earlier
                    int t;
                    t = SCAN * n + SD * (i % 4) + SD - 3;
                    if (t < 4096) img[i] = hist[t][i];
                end
                model_scan(img);
            end
            exp_kpc = ~(4'b0001 << ((cyc / SD) % 4));
            chk("mon_kpc", int'(kpc), int'(exp_kpc));
            chk("mon_valid", int'(key_valid), int'(m_valid));
            chk("mon_code", int'(key_code), int'(m_code));
            chk("mon_held", int'(key_held), int'(m_held));
            if (key_valid) begin pulse_cnt++; last_pulse = cyc; end
            if (!key_held) held_lows++;
        end
    end

    task automatic wait_cyc(input int t);
        int g;
        g = 0;
        while (cyc < t && g < 5000) begin @(negedge clk); g++; end
        if (cyc < t) begin
            failures++;
            $display("FAIL wait_timeout got_cyc=%0d expected_cyc=%0d", cyc, t);
        end
        #1;
    endtask

    task automatic assert_reset();
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_kpc", int'(kpc), 14);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_held", int'(key_held), 0);
        chk("rst_code", int'(key_code), 0);
    endtask

    task automatic release_reset();
        @(negedge clk); #1;
        cyc = 0;
        model_reset();
        pulse_cnt = 0;
        last_pulse = -1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] k;
        int          scans;
        logic        held;
        logic [3:0]  code;
        int          pulses;
    } vec_t;

    vec_t vecs [20];

    initial begin
        vecs[0]  = '{16'h0000, 2, 1'b0, 4'd0,  0};
        vecs[1]  = '{16'h0200, 1, 1'b0, 4'd0,  0};
        vecs[2]  = '{16'h0200, 1, 1'b1, 4'd9,  1};
        vecs[3]  = '{16'h0200, 3, 1'b1, 4'd9,  0};
        vecs[4]  = '{16'h0000, 1, 1'b1, 4'd9,  0};
        vecs[5]  = '{16'h0000, 1, 1'b0, 4'd9,  0};
        vecs[6]  = '{16'h8001, 3, 1'b0, 4'd9,  0};
        vecs[7]  = '{16'h0001, 2, 1'b1, 4'd0,  1};
        vecs[8]  = '{16'h0000, 2, 1'b0, 4'd0,  0};
        vecs[9]  = '{16'h0008, 2, 1'b1, 4'd3,  1};
        vecs[10] = '{16'h1000, 2, 1'b0, 4'd3,  0};
        vecs[11] = '{16'h1000, 2, 1'b1, 4'd12, 1};
        vecs[12] = '{16'h0000, 2, 1'b0, 4'd12, 0};
        vecs[13] = '{16'h0020, 1, 1'b0, 4'd12, 0};
        vecs[14] = '{16'h0040, 1, 1'b0, 4'd12, 0};
        vecs[15] = '{16'h0040, 1, 1'b1, 4'd6,  1};
        vecs[16] = '{16'h0000, 1, 1'b1, 4'd6,  0};
        vecs[17] = '{16'h0040, 2, 1'b1, 4'd6,  0};
        vecs[18] = '{16'h8001, 2, 1'b0, 4'd6,  0};
        vecs[19] = '{16'h0000, 1, 1'b0, 4'd6,  0};

        model_reset();
        #3;
        // Idle scan and asynchronous reset in the middle of column 1.
        release_reset();
        chk("idle_kpc0", int'(kpc), 14);
        wait_cyc(6);
        chk("idle_kpc1", int'(kpc), 13);
        assert_reset();

        // Clean press of key 9 held from reset release.
        keys = 16'h0200;
        release_reset();
        wait_cyc(31);
        chk("press_early_valid", int'(key_valid), 0);
        wait_cyc(32);
        chk("press_valid", int'(key_valid), 1);
        chk("press_code", int'(key_code), 9);
        chk("press_held", int'(key_held), 1);
        keys = 16'h0000;
        wait_cyc(48);
        chk("release_wait_held", int'(key_held), 1);
        wait_cyc(64);
        chk("release_held", int'(key_held), 0);
        chk("press_pulses", pulse_cnt, 1);

        // Table-driven sequences, each aligned to a scan start.
        assert_reset();
        keys = 16'h0000;
        release_reset();
        for (int v = 0; v < 20; v++) begin
            keys = vecs[v].k;
            repeat (SCAN * vecs[v].scans) @(posedge clk);
            @(negedge clk); #1;
            chk($sformatf("vec%0d_held", v), int'(key_held), int'(vecs[v].held));
            chk($sformatf("vec%0d_code", v), int'(key_code), int'(vecs[v].code));
            chk($sformatf("vec%0d_pulses", v), pulse_cnt, vecs[v].pulses);
            pulse_cnt = 0;
        end

        // Bounce on key 5, then steady; then a short dropout while held.
        assert_reset();
        keys = 16'h0000;
        release_reset();
        wait_cyc(18);
        for (int k = 0; k < 13; k++) begin
            keys = (k % 2 == 0) ? 16'h0020 : 16'h0000;
            repeat (3) @(negedge clk);
            #1;
        end
        keys = 16'h0020;
        wait_cyc(160);
        chk("bounce_pulses", pulse_cnt, 1);
        chk("bounce_pulse_cyc", last_pulse, 96);
        chk("bounce_code", int'(key_code), 5);
        held_lows = 0;
        wait_cyc(164);
        keys = 16'h0000;
        wait_cyc(167);
        keys = 16'h0020;
        wait_cyc(224);
        chk("dropout_held_lows", held_lows, 0);
        chk("dropout_pulses", pulse_cnt, 1);

        // Reset in the middle of a press debounce.
        assert_reset();
        keys = 16'h0080;
        release_reset();
        wait_cyc(24);
        chk("middeb_pulses", pulse_cnt, 0);
        assert_reset();
        repeat (3) @(negedge clk);
        release_reset();
        wait_cyc(31);
        chk("middeb_early_valid", int'(key_valid), 0);
        wait_cyc(32);
        chk("middeb_valid", int'(key_valid), 1);
        chk("middeb_code", int'(key_code), 7);
        wait_cyc(48);
        chk("middeb_pulses_total", pulse_cnt, 1);

        // Random key activity checked against the reference model.
        assert_reset();
        keys = 16'h0000;
        release_reset();
        while (cyc < 2300) begin
            int sel;
            int len;
            sel = $urandom_range(0, 9);
            if (sel < 4) keys = 16'h0000;
            else if (sel < 9) keys = 16'h0001 << $urandom_range(0, 15);
            else keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            len = $urandom_range(1, 80);
            repeat (len) @(negedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
